// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side scheduler and its round-robin picker.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Index width that never collapses to zero bits.
   function automatic int clog2(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write port bundle for fifo_wr_arbiter.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   import fifo_arb_pkg::*;

   localparam int ID_W = clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        i_req_valid;
   logic [NUM_REQ*DATA_W-1:0] i_req_data;
   logic [NUM_REQ-1:0]        i_req_last;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic                      i_full;
   logic                      o_wen;
   logic [DATA_W-1:0]         o_wdata;
   logic [ID_W-1:0]           o_grant_id;
   logic                      o_busy;

   modport master (
      output i_req_valid, i_req_data, i_req_last, i_full,
      input  o_req_ready, o_wen, o_wdata, o_grant_id, o_busy
   );

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_full,
      output o_req_ready, o_wen, o_wdata, o_grant_id, o_busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: search starts one past rr_last and wraps.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] rr_last,
   output logic [ID_W-1:0] winner,
   output logic            any_req
);

   function automatic int wrap_idx(input logic [ID_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      return (sum >= N) ? sum - N : sum;
   endfunction

   assign any_req = |req;

   // Walk from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      winner = '0;
      for (int i = N; i >= 1; i--) begin
         if (req[wrap_idx(rr_last, i)]) begin
            winner = ID_W'(wrap_idx(rr_last, i));
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler with burst lock, burst budget and idle timeout,
// driving the FIFO write port and stalling on the write pointer handler's full flag.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int MAX_BURST    = 4,
   parameter int HOLD_TIMEOUT = 8
) (
   input logic               i_wclk,
   input logic               i_rst,
   fifo_wr_arbiter_if.slave  bus
);

   localparam int ID_W = clog2(NUM_REQ);
   localparam int BC_W = clog2(MAX_BURST + 1);
   localparam int IC_W = clog2(HOLD_TIMEOUT + 1);

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   grant_reg, grant_next;
   logic [ID_W-1:0]   rr_last_reg, rr_last_next;
   logic [BC_W-1:0]   burst_cnt_reg, burst_cnt_next;
   logic [IC_W-1:0]   idle_cnt_reg, idle_cnt_next;

   logic [ID_W-1:0]   winner;
   logic              any_req;
   logic [DATA_W-1:0] words [NUM_REQ];
   logic              busy;
   logic              granted_valid;
   logic              granted_last;
   logic              xfer;

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_pick (
      .req     (bus.i_req_valid),
      .rr_last (rr_last_reg),
      .winner  (winner),
      .any_req (any_req)
   );

   assign busy          = (state_reg == BURST);
   assign granted_valid = bus.i_req_valid[grant_reg];
   assign granted_last  = bus.i_req_last[grant_reg];
   assign xfer          = busy && granted_valid && !bus.i_full;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign words[gi]           = bus.i_req_data[gi*DATA_W +: DATA_W];
         assign bus.o_req_ready[gi] = busy && (grant_reg == ID_W'(gi)) && !bus.i_full;
      end
   endgenerate

   assign bus.o_wen      = xfer;
   assign bus.o_wdata    = words[grant_reg];
   assign bus.o_grant_id = grant_reg;
   assign bus.o_busy     = busy;

   always_ff @(posedge i_wclk or posedge i_rst) begin
      if (i_rst) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         rr_last_reg   <= ID_W'(NUM_REQ - 1);
         burst_cnt_reg <= '0;
         idle_cnt_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         rr_last_reg   <= rr_last_next;
         burst_cnt_reg <= burst_cnt_next;
         idle_cnt_reg  <= idle_cnt_next;
      end
   end

   // A full FIFO falls through both branches, freezing both counters during a stall.
   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      rr_last_next   = rr_last_reg;
      burst_cnt_next = burst_cnt_reg;
      idle_cnt_next  = idle_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               grant_next     = winner;
               rr_last_next   = winner;
               burst_cnt_next = '0;
               idle_cnt_next  = '0;
               state_next     = BURST;
            end
         end
         BURST: begin
            if (xfer) begin
               burst_cnt_next = burst_cnt_reg + 1'b1;
               idle_cnt_next  = '0;
               if (granted_last || (burst_cnt_next == BC_W'(MAX_BURST))) begin
                  state_next = IDLE;
               end
            end else if (!granted_valid && !bus.i_full) begin
               idle_cnt_next = idle_cnt_reg + 1'b1;
               if (idle_cnt_next == IC_W'(HOLD_TIMEOUT)) begin
                  state_next = IDLE;
               end
            end
         end
      endcase
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side scheduler for the asynchronous FIFO. It shares the single FIFO write port between NUM_REQ requesters in the write clock domain. It grants round-robin with burst lock and drives the write-enable and data into the write pointer handler, stalling on the handler's combinational full signal. It sits directly in front of the FIFO write port, one per FIFO.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width per requester and of the FIFO write port
MAX_BURST, 4, max transfers per grant before forced release (1..16)
HOLD_TIMEOUT, 8, idle cycles (granted valid low, FIFO not full) before grant is released (1..255)

Ports:
i_wclk  in  1  write-domain clock
i_rst  in  1  asynchronous reset, active-high
i_req_valid  in  NUM_REQ  per-requester data valid
i_req_data  in  NUM_REQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W]
i_req_last  in  NUM_REQ  final word of requester's packet
o_req_ready  out  NUM_REQ  one-hot-or-zero; word accepted when valid&ready
i_full  in  1  combinational full from write pointer handler (next write would overflow)
o_wen  out  1  FIFO write enable
o_wdata  out  DATA_W  FIFO write data
o_grant_id  out  clog2(NUM_REQ)  currently granted requester
o_busy  out  1  high while a grant is held

Behaviour:
- One clock; reset is asynchronous and active-high. All flops are cleared on i_rst.
- Reset values: state IDLE, o_grant_id 0, o_busy 0, burst_cnt 0, idle_cnt 0, rr_last NUM_REQ-1 (requester 0 has first priority). o_wen and o_req_ready are 0 during and after reset until a grant exists.
- States: IDLE, BURST.
- IDLE: if any i_req_valid, pick the winner by rotating priority starting at rr_last+1 mod NUM_REQ. Register o_grant_id=winner and rr_last=winner, clear both counters, then go to BURST. No transfer occurs in IDLE.
- Latency: first transfer no earlier than 1 cycle after valid is seen in IDLE.
- BURST transfer condition: xfer = i_req_valid[g] & ~i_full, where g = o_grant_id.
- BURST outputs (combinational): o_req_ready[g] = ~i_full; o_wen = xfer; o_wdata = i_req_data[g]; all other ready bits 0.
- On each xfer, burst_cnt += 1 and idle_cnt clears.
- BURST to IDLE (registered, one bubble cycle) on any of:
  (a) xfer with i_req_last[g]=1;
  (b) xfer making burst_cnt == MAX_BURST;
  (c) idle_cnt reaching HOLD_TIMEOUT.
  o_busy drops in the same edge.
- idle_cnt increments only when i_req_valid[g]=0 and i_full=0. A full FIFO freezes both counters, so a stall never expires a grant or consumes burst budget.
- Full boundary: while i_full=1, no write and no ready. The word stays held by the requester; nothing is dropped or duplicated. When full deasserts, the transfer resumes in the same cycle.
- Forced release (b) without last: the requester keeps its stream. It re-enters arbitration behind the others, so no requester can starve the rest.
- Non-granted requests are ignored in BURST. Requesters must hold valid/data stable until accepted.
- o_req_ready never asserts for a requester whose valid is low in a way that alters state. Ready may be high with valid low; no transfer occurs.
- Counters are sized clog2(MAX_BURST+1) and clog2(HOLD_TIMEOUT+1) bits. No wrap-around is possible.
- Reset mid-burst: the grant is dropped immediately (async), and the partial packet is the requester's responsibility. Words already written stay in the FIFO.
- Simultaneous last and MAX_BURST on the same transfer: single release, identical to (a).

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state encoding (IDLE=1'b0, BURST=1'b1);
  - the ID-width helper (clog2).
- One sub-module: rr_pick.
  - Pure combinational rotate-priority picker.
  - Inputs: req vector, rr_last. Outputs: winner index, any_req.
  - Reusable for the read-side scheduler.

Test Plan:
1. Reset then valid[0]=1, 3 words, last on word 3, i_full=0: grant_id=0 one cycle after valid; o_wen high exactly 3 consecutive cycles; o_wdata matches words 1..3; o_busy falls after word 3.
2. All 4 requesters valid, single-word packets (last=1): write order 0,1,2,3,0; exactly one bubble cycle between grants.
3. Requester 2 streams 10 words with no last, MAX_BURST=4, requester 1 also valid: bursts 2(4),1(...),2(4),1,2(2). No burst exceeds 4 writes.
4. i_full asserted for 5 cycles mid-burst after word 2: o_wen=0 and ready=0 for those 5 cycles; word 3 is written in the first cycle after full drops; burst_cnt and idle_cnt unchanged across the stall; no duplicate write.
5. Granted requester drops valid with no last, HOLD_TIMEOUT=8: grant is released after 8 idle cycles. If requester 3 is waiting, it is granted next.
6. Assert i_rst mid-burst (word 2 of 4): o_wen, o_busy and o_req_ready go 0 immediately. After release, requester 0 has top priority and word 1 of a new packet is accepted first.
